// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants and RGB332 field layout.
// Default timing is 640x480 @ 60 Hz with a 25 MHz pixel clock derived from
// a 50 MHz system clock. Renderers and sprite blocks import the same values
// so that every block agrees on the frame geometry and the colour packing.
package vga_pkg;

  // Horizontal timing, in pixels
  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

  // Vertical timing, in lines
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  // System clocks per pixel
  localparam int CLK_DIV_DEF   = 2;

  // Width of the pixel_x / pixel_y coordinate buses
  localparam int COORD_W       = 10;

  // RGB332 field positions inside an 8-bit colour byte
  localparam int RGB_R_MSB = 7;
  localparam int RGB_R_LSB = 5;
  localparam int RGB_G_MSB = 4;
  localparam int RGB_G_LSB = 2;
  localparam int RGB_B_MSB = 1;
  localparam int RGB_B_LSB = 0;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  // Split a packed RGB332 byte into its colour fields.
  function automatic rgb332_t rgb332_split(input logic [7:0] c);
    rgb332_t f;
    f.r = c[RGB_R_MSB:RGB_R_LSB];
    f.g = c[RGB_G_MSB:RGB_G_LSB];
    f.b = c[RGB_B_MSB:RGB_B_LSB];
    return f;
  endfunction

endpackage

// File: rtl/vga_pixel_counter.sv
// vga_pixel_counter: clock divider plus horizontal/vertical position counters.
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-high reset
//   pixel_x    - horizontal position, 0..H_TOTAL-1
//   pixel_y    - vertical position, 0..V_TOTAL-1
//   pixel_tick - one-clk pulse, high while the divider sits at CLK_DIV-1
//   frame_wrap - one-clk pulse on the tick that wraps (H_TOTAL-1,V_TOTAL-1) to (0,0)
module vga_pixel_counter
  import vga_pkg::*;
#(
  parameter int H_TOTAL = H_TOTAL_DEF,
  parameter int V_TOTAL = V_TOTAL_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic               clk,
  input  logic               reset,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               pixel_tick,
  output logic               frame_wrap
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_TOTAL - 1);

  logic [DIV_W-1:0]   div_q, div_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               tick;

  always_comb begin
    // Gating with reset keeps the tick low during reset even when CLK_DIV=1,
    // where the divider would otherwise always sit on its last value.
    tick  = (div_q == DIV_LAST) && !reset;
    div_d = tick ? '0 : div_q + 1'b1;
    x_d   = x_q;
    y_d   = y_q;
    if (tick) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      div_q <= div_d;
      x_q   <= x_d;
      y_q   <= y_d;
    end
  end

  assign pixel_x    = x_q;
  assign pixel_y    = y_q;
  assign pixel_tick = tick;
  assign frame_wrap = tick && (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing with a registered colour/sync output stage.
// Ports:
//   clk, reset         - system clock; asynchronous active-high reset
//   pixel_x, pixel_y   - current raster position (pre-output-register)
//   pixel_tick         - one-clk pulse per pixel period
//   video_on           - current position is inside the visible window
//   frame_start        - one-clk pulse on the tick that wraps to (0,0)
//   color_in           - RGB332 colour for the current position, from renderers
//   vga_r/vga_g/vga_b  - registered colour, blanked outside the visible window
//   hsync, vsync       - registered active-low sync
// Colour and sync are both registered on the pixel tick, so they lag
// pixel_x/pixel_y by exactly one pixel and stay aligned with each other.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter int CLK_DIV   = CLK_DIV_DEF
) (
  input  logic               clk,
  input  logic               reset,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               pixel_tick,
  output logic               video_on,
  output logic               frame_start,
  input  logic [7:0]         color_in,
  output logic [2:0]         vga_r,
  output logic [2:0]         vga_g,
  output logic [1:0]         vga_b,
  output logic               hsync,
  output logic               vsync
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COORD_W-1:0] H_VIS_C   = COORD_W'(H_VISIBLE);
  localparam logic [COORD_W-1:0] H_SYNC_LO = COORD_W'(H_VISIBLE + H_FRONT);
  localparam logic [COORD_W-1:0] H_SYNC_HI = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [COORD_W-1:0] V_VIS_C   = COORD_W'(V_VISIBLE);
  localparam logic [COORD_W-1:0] V_SYNC_LO = COORD_W'(V_VISIBLE + V_FRONT);
  localparam logic [COORD_W-1:0] V_SYNC_HI = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic    tick;
  logic    hsync_raw, vsync_raw;
  rgb332_t rgb_q, rgb_d;
  logic    hsync_q, hsync_d;
  logic    vsync_q, vsync_d;

  vga_pixel_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .CLK_DIV (CLK_DIV)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .pixel_tick (tick),
    .frame_wrap (frame_start)
  );

  always_comb begin
    video_on  = (pixel_x < H_VIS_C) && (pixel_y < V_VIS_C);
    // Raw sync conditions are active-low: low inside the sync window.
    hsync_raw = !((pixel_x >= H_SYNC_LO) && (pixel_x < H_SYNC_HI));
    vsync_raw = !((pixel_y >= V_SYNC_LO) && (pixel_y < V_SYNC_HI));

    rgb_d   = rgb_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    if (tick) begin
      rgb_d   = video_on ? rgb332_split(color_in) : '0;
      hsync_d = hsync_raw;
      vsync_d = vsync_raw;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q   <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      rgb_q   <= rgb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign pixel_tick = tick;
  assign vga_r      = rgb_q.r;
  assign vga_g      = rgb_q.g;
  assign vga_b      = rgb_q.b;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch in pixels
- H_SYNC, 96, hsync pulse width in pixels
- H_BACK, 48, horizontal back porch in pixels
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch in lines
- V_SYNC, 2, vsync pulse width in lines
- V_BACK, 33, vertical back porch in lines
- CLK_DIV, 2, system clocks per pixel (50 MHz to 25 MHz)

REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk, in, 1, single system clock, rising edge
- reset, in, 1, asynchronous active-high reset
- pixel_x, out, 10, current horizontal count, 0..H_TOTAL-1
- pixel_y, out, 10, current vertical count, 0..V_TOTAL-1
- pixel_tick, out, 1, one-clk pulse marking each pixel period
- video_on, out, 1, high when pixel_x < H_VISIBLE and pixel_y < V_VISIBLE
- frame_start, out, 1, one-clk pulse on the pixel_tick where the counters wrap to (0,0)
- color_in, in, 8, RGB332 colour for (pixel_x, pixel_y), combinational from downstream renderers
- vga_r, out, 3, registered red output
- vga_g, out, 3, registered green output
- vga_b, out, 2, registered blue output
- hsync, out, 1, active-low, registered
- vsync, out, 1, active-low, registered

Function
REQ-003 H_TOTAL SHALL equal H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL SHALL equal the vertical sum (525).
REQ-004 A divider counter SHALL count 0..CLK_DIV-1 and wrap. pixel_tick SHALL be high for exactly one clk when the divider equals CLK_DIV-1.
REQ-005 pixel_x SHALL increment only on pixel_tick. It SHALL wrap from H_TOTAL-1 to 0.
REQ-006 pixel_y SHALL increment only on the pixel_tick where pixel_x wraps. It SHALL wrap from V_TOTAL-1 to 0 on that same tick.
REQ-007 frame_start SHALL assert on the pixel_tick where pixel_x=H_TOTAL-1 and pixel_y=V_TOTAL-1, in the same clk as the tick.
REQ-008 video_on SHALL be combinational from the current pixel_x and pixel_y.
REQ-009 The raw hsync condition SHALL be active (low) for H_VISIBLE+H_FRONT <= pixel_x < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
REQ-010 The raw vsync condition SHALL be active (low) for 490 <= pixel_y < 492, by the equivalent rule.
REQ-011 Output stage: on each pixel_tick, the block SHALL register {vga_r,vga_g,vga_b} <= video_on ? {color_in[7:5], color_in[4:2], color_in[1:0]} : 0.
REQ-012 On the same pixel_tick, the block SHALL register hsync and vsync from their raw conditions.
REQ-013 Colour and sync outputs SHALL therefore lag pixel_x/pixel_y by exactly one pixel period and SHALL stay mutually aligned.
REQ-014 Between pixel_ticks, all registered outputs SHALL hold their values.
REQ-015 Outside the visible area, RGB outputs SHALL be 0 regardless of color_in.

Reset
REQ-016 While reset is high, the following SHALL be forced asynchronously:
- divider=0, pixel_x=0, pixel_y=0
- pixel_tick=0, frame_start=0
- vga_r=vga_g=vga_b=0
- hsync=1, vsync=1
REQ-017 The first pixel_tick after reset deasserts SHALL occur CLK_DIV clks later.
REQ-018 A reset asserted mid-line or mid-frame SHALL abandon the frame. Counting SHALL restart at (0,0) with no partial sync pulse continued.

Structure
REQ-019 A shared package vga_pkg SHALL hold the timing constants (visible, porch and sync widths, totals) and the RGB332 field positions. The renderer and sprite blocks SHALL import the same values.
REQ-020 One sub-module SHALL exist: vga_pixel_counter, containing the divider plus the x and y counters with their tick and wrap outputs. Sync decode and the output register SHALL stay in vga_timing_gen.

Verification
REQ-021 Reset release, then run 1 frame -> pixel_tick period is 2 clks; 800*525 ticks elapse between consecutive frame_start pulses (840000 clks).
REQ-022 Line timing -> hsync low for exactly 96 ticks, with the first low output on the tick after pixel_x=656; vsync low for exactly 2 lines, starting after pixel_y=490.
REQ-023 color_in=8'hE0 constant -> vga_r=3'b111, vga_g=0, vga_b=0 in the visible area; all RGB outputs are 0 at pixel_x=640..799 and at pixel_y>=480.
REQ-024 color_in driven as pixel_x[7:0] -> the registered RGB at tick n+1 equals the split of the value presented at tick n (one-pixel latency check).
REQ-025 Assert reset at pixel_x=300, pixel_y=200 for 3 clks -> all outputs take their reset values immediately; after release, counting resumes from (0,0).
REQ-026 Wrap check -> at (799,524) the next tick gives (0,0), with frame_start high in the tick clk only.
